// File: rtl/ram_arb_pkg.sv
// Shared constants for the dual_ram port arbiter: requester ids, FSM encoding, default sizes.
// Optional round-robin arbitration is enabled with the RAM_ARB_RR_EN macro.
package ram_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 12;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ram_arb_grant2.sv
// Two-input grant generator: fixed req0-first priority, or pointer-selected
// round-robin when RAM_ARB_RR_EN is defined.
module ram_arb_grant2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

`ifndef RAM_ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ptr_i;
`endif

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
`ifdef RAM_ARB_RR_EN
      gnt_o = ptr_i ? 2'b10 : 2'b01;
`else
      gnt_o = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one dual_ram between the core (req0) and the loader/debug port (req1).
// Write and read channels arbitrate independently; RAM_ARB_RR_EN selects round-robin.
//
// Handshake: an operation transfers when reqN_valid && reqN_ready are both high in
// the same cycle; ready is combinational and requesters hold their request until ready.
// Read responses are single-cycle pulses one cycle after the grant and are never stalled.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,
  output arb_state_e    dbg_state_o
);

  logic [1:0] w_req, r_req, w_gnt, r_gnt, r_issue;
  logic       ptr_w, ptr_r;
  logic       collide;

  arb_state_e state_q, state_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_tag_q, rsp_tag_d;

  assign w_req = {req1_valid & req1_we, req0_valid & req0_we} & {2{~rst}};
  assign r_req = {req1_valid & ~req1_we, req0_valid & ~req0_we} & {2{~rst}};

  ram_arb_grant2 u_grant_w (.req_i(w_req), .ptr_i(ptr_w), .gnt_o(w_gnt));
  ram_arb_grant2 u_grant_r (.req_i(r_req), .ptr_i(ptr_r), .gnt_o(r_gnt));

  assign ram_w_addr = w_gnt[1] ? req1_addr : req0_addr;
  assign ram_w_data = w_gnt[1] ? req1_wdata : req0_wdata;
  assign ram_r_addr = r_gnt[1] ? req1_addr : req0_addr;

  // Same-address read is held back a cycle so it never relies on RAM bypass.
  assign collide  = (|w_gnt) & (|r_gnt) & (ram_w_addr == ram_r_addr);
  assign r_issue  = r_gnt & {2{~collide}};
  assign ram_w_en = |w_gnt;
  assign ram_r_en = |r_issue;

  assign req0_ready = w_gnt[0] | r_issue[0];
  assign req1_ready = w_gnt[1] | r_issue[1];

  always_comb begin
    state_d     = collide ? ST_STALL : ST_IDLE;
    rsp_valid_d = ram_r_en;
    rsp_tag_d   = r_issue[1] ? REQ_LOAD : REQ_CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= REQ_CORE;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
    end
  end

`ifdef RAM_ARB_RR_EN
  logic ptr_w_q, ptr_w_d, ptr_r_q, ptr_r_d;

  // Pointer names the loser of the last grant; a stalled read does not move it.
  always_comb begin
    ptr_w_d = ptr_w_q;
    ptr_r_d = ptr_r_q;
    if (|w_gnt) ptr_w_d = w_gnt[0] ? REQ_LOAD : REQ_CORE;
    if (|r_issue) ptr_r_d = r_issue[0] ? REQ_LOAD : REQ_CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_w_q <= REQ_CORE;
      ptr_r_q <= REQ_CORE;
    end else begin
      ptr_w_q <= ptr_w_d;
      ptr_r_q <= ptr_r_d;
    end
  end

  assign ptr_w = ptr_w_q;
  assign ptr_r = ptr_r_q;
`else
  assign ptr_w = REQ_CORE;
  assign ptr_r = REQ_CORE;
`endif

  assign rsp0_valid  = rsp_valid_q & ~rst & (rsp_tag_q == REQ_CORE);
  assign rsp1_valid  = rsp_valid_q & ~rst & (rsp_tag_q == REQ_LOAD);
  assign rsp0_rdata  = ram_r_data;
  assign rsp1_rdata  = ram_r_data;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter with a behavioural dual_ram; expectations follow
// fixed priority by default and alternation when RAM_ARB_RR_EN is defined.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk, rst;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          ram_w_en, ram_r_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  arb_state_e    dbg_state;

  ram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h030] = 32'h2222_2222;
    ram_r_data = '0;
  end
  always @(posedge clk) begin
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          rdy0, rdy1, wen, ren, rsp0, rsp1, stall;
    logic [DW-1:0] rdata;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  initial begin
    int w;
    int prev_w;
    logic [DW-1:0] exp_d;

    // v0 we0 a0 d0 | v1 we1 a1 d1 | rdy0 rdy1 wen ren rsp0 rsp1 stall rdata
    tbl[0]  = '{1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b1, 12'h020, 32'h11111111, 1'b1, 1'b0, 12'h030, 32'h0,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222};
    tbl[5]  = '{1'b1, 1'b1, 12'h040, 32'hA5A5A5A5, 1'b1, 1'b0, 12'h040, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h040, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5};
    tbl[8]  = '{1'b1, 1'b0, 12'h020, 32'h0, 1'b1, 1'b1, 12'h060, 32'h33333333,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h060, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h11111111};
    tbl[10] = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33333333};
    tbl[11] = '{1'b1, 1'b0, 12'h070, 32'h0, 1'b1, 1'b1, 12'h070, 32'h00000044,
                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 12'h070, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000044};

    // ---------------- reset (requests present, nothing may be granted) ----------------
    rst = 1'b1;
    drive(1'b1, 1'b1, 12'h100, 32'hFFFF0000, 1'b1, 1'b0, 12'h101, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("reset_rdy0[%0d]", i), req0_ready, 1'b0);
      chk1($sformatf("reset_rdy1[%0d]", i), req1_ready, 1'b0);
      chk1($sformatf("reset_wen[%0d]", i), ram_w_en, 1'b0);
      chk1($sformatf("reset_ren[%0d]", i), ram_r_en, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk1("post_reset_rsp0", rsp0_valid, 1'b0);
    chk1("post_reset_rsp1", rsp1_valid, 1'b0);
    chk("post_reset_state", {31'b0, dbg_state}, {31'b0, ST_IDLE});

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk1($sformatf("v%0d_rdy0", i), req0_ready, tbl[i].rdy0);
      chk1($sformatf("v%0d_rdy1", i), req1_ready, tbl[i].rdy1);
      chk1($sformatf("v%0d_wen", i), ram_w_en, tbl[i].wen);
      chk1($sformatf("v%0d_ren", i), ram_r_en, tbl[i].ren);
      chk1($sformatf("v%0d_rsp0", i), rsp0_valid, tbl[i].rsp0);
      chk1($sformatf("v%0d_rsp1", i), rsp1_valid, tbl[i].rsp1);
      chk1($sformatf("v%0d_stall", i), dbg_state == ST_STALL, tbl[i].stall);
      if (tbl[i].wen) begin
        chk($sformatf("v%0d_waddr", i), {20'b0, ram_w_addr},
            {20'b0, (tbl[i].rdy0 && tbl[i].we0) ? tbl[i].a0 : tbl[i].a1});
        chk($sformatf("v%0d_wdata", i), ram_w_data,
            (tbl[i].rdy0 && tbl[i].we0) ? tbl[i].d0 : tbl[i].d1);
      end
      if (tbl[i].ren)
        chk($sformatf("v%0d_raddr", i), {20'b0, ram_r_addr},
            {20'b0, (tbl[i].rdy0 && !tbl[i].we0) ? tbl[i].a0 : tbl[i].a1});
      if (tbl[i].rsp0) chk($sformatf("v%0d_rdata0", i), rsp0_rdata, tbl[i].rdata);
      if (tbl[i].rsp1) chk($sformatf("v%0d_rdata1", i), rsp1_rdata, tbl[i].rdata);
    end

    // ---------------- reset while a read is in flight ----------------
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("rstmid_grant", req0_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1($sformatf("rstmid_rsp0[%0d]", i), rsp0_valid, 1'b0);
      chk1($sformatf("rstmid_rsp1[%0d]", i), rsp1_valid, 1'b0);
      chk1($sformatf("rstmid_rdy0[%0d]", i), req0_ready, 1'b0);
      chk1($sformatf("rstmid_ren[%0d]", i), ram_r_en, 1'b0);
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("rstmid_after_rdy0", req0_ready, 1'b1);
    chk1("rstmid_after_ren", ram_r_en, 1'b1);
    chk1("rstmid_after_norsp", rsp0_valid, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk1("rstmid_after_rsp0", rsp0_valid, 1'b1);
    chk("rstmid_after_rdata", rsp0_rdata, 32'h11111111);

    // ---------------- read contention, pointers freshly reset ----------------
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prev_w = -1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b1, 1'b0, 12'h030, 32'h0);
      else       idle_inputs();
      @(negedge clk);
      chk1($sformatf("cont%0d_rsp0", i), rsp0_valid, prev_w == 0);
      chk1($sformatf("cont%0d_rsp1", i), rsp1_valid, prev_w == 1);
      if (prev_w >= 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cont%0d_queue actual=empty expected=entry", i);
        end else begin
          exp_d = exp_q.pop_front();
          chk($sformatf("cont%0d_rdata", i), (prev_w == 0) ? rsp0_rdata : rsp1_rdata, exp_d);
        end
      end
      if (i < 4) begin
        w = RR ? (i % 2) : 0;
        chk1($sformatf("cont%0d_rdy0", i), req0_ready, w == 0);
        chk1($sformatf("cont%0d_rdy1", i), req1_ready, w == 1);
        chk1($sformatf("cont%0d_ren", i), ram_r_en, 1'b1);
        chk1($sformatf("cont%0d_wen", i), ram_w_en, 1'b0);
        exp_q.push_back((w == 0) ? 32'hDEADBEEF : 32'h22222222);
        prev_w = w;
      end else begin
        prev_w = -1;
      end
    end

    // ---------------- idle ----------------
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk1($sformatf("idle%0d_wen", i), ram_w_en, 1'b0);
      chk1($sformatf("idle%0d_ren", i), ram_r_en, 1'b0);
      chk1($sformatf("idle%0d_rsp0", i), rsp0_valid, 1'b0);
      chk1($sformatf("idle%0d_rsp1", i), rsp1_valid, 1'b0);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one dual_ram instance between two requesters: the core load/store path (req0) and the program loader/debug port (req1).
- The write port and the read port of the RAM are arbitrated independently, so one write and one read can issue in the same cycle.
- Read data is returned to the owning requester with a tagged, 1-cycle-latency response.
- The block sits between the requesters and the dual_ram ports; it adds no storage except the response tag and the arbitration state.

Parameters:
DW, 32, data width; must match the RAM.
AW, 12, address width (word address); must match the RAM.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_we  in  1  1 = write, 0 = read
req0_addr  in  AW  word address
req0_wdata  in  DW  write data
req0_ready  out  1  operation accepted this cycle
rsp0_valid  out  1  read data valid for requester 0
rsp0_rdata  out  DW  read data
req1_valid / req1_we / req1_addr / req1_wdata / req1_ready / rsp1_valid / rsp1_rdata  (same as above, requester 1)
ram_w_en  out  1  RAM write enable
ram_w_addr  out  AW  RAM write address
ram_w_data  out  DW  RAM write data
ram_r_en  out  1  RAM read enable
ram_r_addr  out  AW  RAM read address
ram_r_data  in  DW  RAM read data (registered, 1 cycle after ram_r_en)

Behaviour:
Reset:
- rst=1 at a clk edge clears rsp0_valid, rsp1_valid, the response tag, both priority pointers and the stall flag.
- While rst=1, all ready and ram enables are 0.
- A read in flight when rst asserts is dropped and no response is produced.

Handshake:
- An operation transfers when reqN_valid && reqN_ready in the same cycle.
- ready is combinational from valid, we, addr and the arbitration state.
- Requesters hold valid, we, addr and wdata stable until ready.

Write channel:
- Candidates are requesters with valid && we.
- The winner drives ram_w_en, ram_w_addr and ram_w_data combinationally in the grant cycle and gets ready=1.
- The loser gets ready=0.

Read channel:
- Candidates are requesters with valid && !we.
- The winner drives ram_r_en and ram_r_addr and gets ready=1.
- A requester presents one operation per cycle, so it can never win both channels at once.

Read response:
- The RAM data is returned on rspN_rdata with rspN_valid=1 exactly 1 cycle after the grant, where N is the registered grant tag.
- rsp valids are 1-cycle pulses.
- A response is never back-pressured.

Collision stall (state IDLE/STALL):
- If a read grant and a write grant in the same cycle target the same address, the read is not issued: its ready=0 and the state goes to STALL.
- The write still issues.
- In STALL the read is re-arbitrated the next cycle and observes the new data.
- The state returns to IDLE after one cycle.
- Consequence: a read never depends on the RAM's same-address bypass.

Priority:
- Default (macro off) is fixed priority, req0 over req1, on both channels.
- The pointer logic is described under Optional Feature.

Idle:
- With no valid requests, ram_w_en=0 and ram_r_en=0.
- ram address and data outputs are don't-care.

Optional Feature:
RAM_ARB_RR_EN
- Defined: each channel keeps a 1-bit round-robin pointer.
  - On a contested grant the requester named by the pointer wins.
  - On every grant the pointer moves to the other requester.
  - An uncontested grant also updates the pointer.
  - The read pointer does not update on a stalled (not granted) cycle.
- Undefined: fixed priority req0 > req1 and no pointer flops.

Decomposition:
- Shared package ram_arb_pkg holds:
  - requester id constants (REQ_CORE=0, REQ_LOAD=1);
  - the state encoding (ST_IDLE, ST_STALL);
  - default DW/AW localparams.
- One sub-module, ram_arb_grant2: a 2-input grant generator (req[1:0], ptr, gnt[1:0]) with fixed/round-robin selected by the macro.
- It is instantiated once per channel.

Test Plan:
- Single write then read, req0 only: write addr 0x010 data 0xDEADBEEF, next cycle read 0x010 -> req0_ready=1 both cycles, rsp0_valid pulses 1 cycle after the read grant with 0xDEADBEEF, rsp1_valid stays 0.
- Parallel channels: req0 writes 0x020=0x11111111 while req1 reads 0x030 (preloaded 0x22222222) -> both ready=1 in the same cycle, ram_w_en=ram_r_en=1, rsp1_rdata=0x22222222 next cycle.
- Collision: req0 writes 0x040=0xA5A5A5A5 and req1 reads 0x040 (old value 0) in the same cycle -> req1_ready=0 that cycle, req1_ready=1 next cycle, and rsp1_rdata=0xA5A5A5A5 one cycle later.
- Contention: both read for 4 cycles, macro off -> req0 granted every cycle and req1_ready=0. Macro on -> grants alternate 0,1,0,1.
- Reset mid-read: read granted at cycle t, rst=1 at cycle t+1 -> no rsp pulse, all ready=0 during reset, and the first request after reset is accepted normally.
- Idle: no valid requests for 10 cycles -> ram_w_en=ram_r_en=0 and no rsp pulses.
